// File: rtl/logical_tile_io_bank.sv
// logical_tile_io_bank
// Multi-pad perimeter I/O tile. Every pad has its own 3-bit configuration
// row {OREG, IREG, DIR}, written from bl when the matching wl bit is high.
// Each pad can be an output (combinational or registered) or an input
// (combinational or synchronised). Synchronised inputs also produce a
// one-cycle change pulse, which is held off until the synchroniser has
// refilled after reset.
module logical_tile_io_bank #(
  parameter int NUM_PADS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] io_outpad,
  input  logic [2:0]          bl,
  input  logic [NUM_PADS-1:0] wl,
  output logic [NUM_PADS-1:0] io_inpad,
  output logic [NUM_PADS-1:0] io_inpad_edge
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES);

  // Configuration rows, one bit per pad for each field.
  logic [NUM_PADS-1:0] dir_q, dir_d;
  logic [NUM_PADS-1:0] ireg_q, ireg_d;
  logic [NUM_PADS-1:0] oreg_sel_q, oreg_sel_d;

  // Data path state.
  logic [NUM_PADS-1:0]                   oreg_q, oreg_d;
  logic [SYNC_STAGES-1:0][NUM_PADS-1:0]  sync_q, sync_d;
  logic [NUM_PADS-1:0]                   last_q, last_d;
  logic [CNT_W-1:0]                      warm_cnt_q, warm_cnt_d;

  logic [NUM_PADS-1:0] pad_in;
  logic [NUM_PADS-1:0] pad_out;
  logic [NUM_PADS-1:0] sync_last;
  logic                warm;

  // The resolved pad value: the external driver for inputs, our own driver
  // for outputs. The synchroniser samples this in both directions.
  assign pad_in    = gfpga_pad_GPIO_PAD;
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign warm      = (warm_cnt_q == WARM_MAX);

  // Row writes: every selected row takes the same bl word; others hold.
  // NOTE: every always_comb output gets a default first so a missing branch
  // can never infer a latch.
  always_comb begin
    dir_d      = dir_q;
    ireg_d     = ireg_q;
    oreg_sel_d = oreg_sel_q;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (wl[i]) begin
        dir_d[i]      = bl[0];
        ireg_d[i]     = bl[1];
        oreg_sel_d[i] = bl[2];
      end
    end
  end

  // Next state for output register, synchroniser, change history and warm-up.
  always_comb begin
    oreg_d = io_outpad;
    sync_d = sync_q;
    sync_d[0] = pad_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    last_d     = sync_last;
    warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + CNT_W'(1);
  end

  // All state updates; reset wins over a simultaneous row write.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= '0;
      ireg_q     <= '0;
      oreg_sel_q <= '0;
      oreg_q     <= '0;
      sync_q     <= '0;
      last_q     <= '0;
      warm_cnt_q <= '0;
    end else begin
      dir_q      <= dir_d;
      ireg_q     <= ireg_d;
      oreg_sel_q <= oreg_sel_d;
      oreg_q     <= oreg_d;
      sync_q     <= sync_d;
      last_q     <= last_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Output data selection: registered copy or straight from the fabric.
  always_comb begin
    pad_out = (oreg_sel_q & oreg_q) | (~oreg_sel_q & io_outpad);
  end

  // Pad drivers: only pads configured as outputs are driven.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad_drv
    assign gfpga_pad_GPIO_PAD[i] = dir_q[i] ? pad_out[i] : 1'bz;
  end

  // Fabric-side input data and change pulse; outputs never loop back.
  always_comb begin
    io_inpad      = ~dir_q & ((ireg_q & sync_last) | (~ireg_q & pad_in));
    io_inpad_edge = (sync_last ^ last_q) & ~dir_q & ireg_q & {NUM_PADS{warm}};
  end

endmodule

// File: tb/tb_logical_tile_io_bank.sv
// Testbench for logical_tile_io_bank: directed scenarios followed by random
// traffic. A stimulus process pushes the expected per-cycle outputs from a
// history-based reference model; an independent monitor pops and compares.
module tb_logical_tile_io_bank;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] io_outpad;
  logic [2:0]   bl;
  logic [N-1:0] wl;
  logic [N-1:0] io_inpad;
  logic [N-1:0] io_inpad_edge;
  logic [N-1:0] ext_val;
  logic [N-1:0] ext_en;
  wire  [N-1:0] pad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  logical_tile_io_bank #(.NUM_PADS(N), .SYNC_STAGES(S)) dut (
    .clk               (clk),
    .reset             (reset),
    .gfpga_pad_GPIO_PAD(pad),
    .io_outpad         (io_outpad),
    .bl                (bl),
    .wl                (wl),
    .io_inpad          (io_inpad),
    .io_inpad_edge     (io_inpad_edge)
  );

  // ---------------- reference model ----------------
  // Configuration as plain per-pad fields, the output register as the last
  // sampled io_outpad, and the input path as a history of sampled pad words:
  // the synchronised value is the sample taken S-1 edges ago.
  logic [N-1:0] m_dir, m_ireg, m_osel, m_oreg;
  logic [N-1:0] m_hist[$];
  int           m_edges_since_reset;

  typedef struct {
    logic [N-1:0] inpad;
    logic [N-1:0] edg;
    logic [N-1:0] pad;
  } exp_t;

  exp_t sb[$];

  function automatic logic [N-1:0] model_pad();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++)
      p[i] = m_dir[i] ? (m_osel[i] ? m_oreg[i] : io_outpad[i]) : ext_val[i];
    return p;
  endfunction

  function automatic logic [N-1:0] hist_back(input int age);
    // age 0 = most recent sample; samples older than reset read as zero
    if (m_hist.size() > age) return m_hist[m_hist.size() - 1 - age];
    return '0;
  endfunction

  task automatic model_clock();
    logic [N-1:0] p;
    p = model_pad();
    if (reset) begin
      m_dir = '0; m_ireg = '0; m_osel = '0; m_oreg = '0;
      m_hist.delete();
      m_edges_since_reset = 0;
    end else begin
      m_hist.push_back(p);
      if (m_hist.size() > S + 1) void'(m_hist.pop_front());
      if (m_edges_since_reset < S) m_edges_since_reset++;
      m_oreg = io_outpad;
      for (int i = 0; i < N; i++) begin
        if (wl[i]) begin
          m_dir[i]  = bl[0];
          m_ireg[i] = bl[1];
          m_osel[i] = bl[2];
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    logic [N-1:0] sync_now, sync_prev;
    logic warm;
    sync_now  = hist_back(S - 1);
    sync_prev = hist_back(S);
    warm      = (m_edges_since_reset >= S);
    e.pad     = model_pad();
    for (int i = 0; i < N; i++) begin
      if (m_dir[i])       e.inpad[i] = 1'b0;
      else if (m_ireg[i]) e.inpad[i] = sync_now[i];
      else                e.inpad[i] = e.pad[i];
      e.edg[i] = warm && !m_dir[i] && m_ireg[i] && (sync_now[i] != sync_prev[i]);
    end
    sb.push_back(e);
  endtask

  // One cycle: advance model at the edge, then apply new inputs and record
  // what the DUT must show for the rest of this cycle.
  task automatic step(input logic r, input logic [N-1:0] w, input logic [2:0] b,
                      input logic [N-1:0] o, input logic [N-1:0] e);
    @(posedge clk);
    model_clock();
    #1;
    reset     = r;
    wl        = w;
    bl        = b;
    io_outpad = o;
    ext_val   = e;
    ext_en    = ~m_dir;
    push_expected();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("io_inpad", io_inpad, e.inpad);
      check("io_inpad_edge", io_inpad_edge, e.edg);
      check("pad", pad, e.pad);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] ext;
    reset = 1'b1; wl = '0; bl = '0; io_outpad = '0;
    ext_val = 4'b1010; ext_en = '1;
    m_dir = '0; m_ireg = '0; m_osel = '0; m_oreg = '0;
    m_edges_since_reset = 0;

    // Reset with pads externally at 1010, then hold idle after release.
    step(1'b1, '0, 3'b000, '0, 4'b1010);
    step(1'b1, '0, 3'b000, '0, 4'b1010);
    for (int c = 0; c < S + 3; c++) step(1'b0, '0, 3'b000, '0, 4'b1010);

    // Output mode on pad0: combinational, then registered.
    step(1'b0, 4'b0001, 3'b001, 4'b0000, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0001, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0000, 4'b1010);
    step(1'b0, 4'b0001, 3'b101, 4'b0001, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0000, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0001, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0001, 4'b1010);
    step(1'b0, '0,      3'b000, 4'b0000, 4'b1010);

    // Registered input on pad1: 0->1 and 1->0 transitions.
    step(1'b0, 4'b0010, 3'b010, '0, 4'b0000);
    for (int c = 0; c < S + 1; c++) step(1'b0, '0, 3'b000, '0, 4'b0000);
    for (int c = 0; c < S + 2; c++) step(1'b0, '0, 3'b000, '0, 4'b0010);
    for (int c = 0; c < S + 2; c++) step(1'b0, '0, 3'b000, '0, 4'b0000);

    // Multi-row write: every pad becomes a combinational output.
    step(1'b0, 4'b1111, 3'b001, 4'b0110, 4'b0000);
    step(1'b0, '0,      3'b000, 4'b1001, 4'b0000);
    step(1'b0, '0,      3'b000, 4'b0110, 4'b0000);

    // Reset mid-drive, then reset coinciding with a row write.
    step(1'b1, '0,      3'b000, 4'b1111, 4'b0101);
    step(1'b0, '0,      3'b000, 4'b1111, 4'b0101);
    step(1'b0, '0,      3'b000, 4'b1111, 4'b1100);
    step(1'b1, 4'b1111, 3'b111, 4'b1111, 4'b0011);
    step(1'b0, '0,      3'b000, 4'b1111, 4'b0011);
    step(1'b0, '0,      3'b000, 4'b0000, 4'b1001);
    for (int c = 0; c < S + 1; c++) step(1'b0, '0, 3'b000, '0, 4'b1001);

    // Direction flip on pad2: output with toggling data, then IREG input.
    step(1'b0, 4'b0100, 3'b001, 4'b0000, 4'b0000);
    for (int c = 0; c < 4; c++) step(1'b0, '0, 3'b000, (c % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000);
    step(1'b0, '0,      3'b000, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 3'b010, 4'b0000, 4'b0100);
    for (int c = 0; c < S + 3; c++) step(1'b0, '0, 3'b000, '0, 4'b0100);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      logic r;
      logic [N-1:0] w;
      r   = ($urandom_range(0, 39) == 0);
      w   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      ext = N'($urandom);
      step(r, w, 3'($urandom), N'($urandom), ext);
      if ($urandom_range(0, 2) != 0) begin
        // hold external data a few cycles so synchronised paths see stable values
        for (int h = 0; h < int'($urandom_range(1, 3)); h++)
          step(1'b0, '0, 3'($urandom), N'($urandom), ext);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int c = 0; c < 5 && sb.size() > 0; c++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
